// File: rtl/noc_packet_injector_pkg.sv
// Shared widths, flit types, head-flit field layout and mesh size for the NoC packet injector.
package noc_packet_injector_pkg;

  localparam int unsigned FLIT_DATA_W = 32;
  localparam int unsigned COORD_W     = 4;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned SEQ_W       = 4;

  localparam int unsigned NocXSize = 4;
  localparam int unsigned NocYSize = 4;

  localparam int unsigned HeadDstXOff = 28;
  localparam int unsigned HeadDstYOff = 24;
  localparam int unsigned HeadSrcXOff = 20;
  localparam int unsigned HeadSrcYOff = 16;
  localparam int unsigned HeadLenOff  = 12;
  localparam int unsigned HeadSeqOff  = 8;

  typedef enum logic [1:0] {
    FlitHead     = 2'd0,
    FlitBody     = 2'd1,
    FlitTail     = 2'd2,
    FlitHeadTail = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StSendHead,
    StSendPld
  } inj_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [LEN_W-1:0]   len;
  } desc_t;

  localparam int unsigned DescW = $bits(desc_t);

  function automatic logic [FLIT_DATA_W-1:0] head_word(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LEN_W-1:0]   len,
    input logic [SEQ_W-1:0]   seq
  );
    logic [FLIT_DATA_W-1:0] w;
    w = '0;
    w[HeadDstXOff +: COORD_W] = dst_x;
    w[HeadDstYOff +: COORD_W] = dst_y;
    w[HeadSrcXOff +: COORD_W] = src_x;
    w[HeadSrcYOff +: COORD_W] = src_y;
    w[HeadLenOff +: LEN_W]    = len;
    w[HeadSeqOff +: SEQ_W]    = seq;
    return w;
  endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Descriptor, payload and flit handshake bundle; master is the injector, slave its environment.
interface noc_packet_injector_if;
  import noc_packet_injector_pkg::*;

  logic                   desc_valid;
  logic                   desc_ready;
  logic [COORD_W-1:0]     desc_dst_x;
  logic [COORD_W-1:0]     desc_dst_y;
  logic [LEN_W-1:0]       desc_len;
  logic                   pld_valid;
  logic                   pld_ready;
  logic [FLIT_DATA_W-1:0] pld_data;
  logic                   flit_valid;
  logic                   flit_ready;
  flit_type_e             flit_type;
  logic [FLIT_DATA_W-1:0] flit_data;
  logic                   err_drop;

  modport master (
    input  desc_valid, desc_dst_x, desc_dst_y, desc_len,
    output desc_ready,
    input  pld_valid, pld_data,
    output pld_ready,
    output flit_valid, flit_type, flit_data,
    input  flit_ready,
    output err_drop
  );

  modport slave (
    output desc_valid, desc_dst_x, desc_dst_y, desc_len,
    input  desc_ready,
    output pld_valid, pld_data,
    input  pld_ready,
    input  flit_valid, flit_type, flit_data,
    output flit_ready,
    input  err_drop
  );

endinterface

// File: rtl/noc_inj_desc_fifo.sv
// In-order descriptor FIFO with synchronous active-low reset; Depth must be a power of 2.
module noc_inj_desc_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push_en, pop_en;

  assign full    = (cnt_q == (PtrW + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Turns queued descriptors plus payload words into HEAD/BODY/TAIL flits for a router local port.
// Define NOC_INJ_STATS_EN to add saturating packet and stall counters.
module noc_packet_injector
  import noc_packet_injector_pkg::*;
#(
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  noc_packet_injector_if.master        inj
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]                  stat_pkt_cnt,
  output logic [15:0]                  stat_stall_cnt
`endif
);

  desc_t      fifo_wdata, fifo_rdata;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;

  inj_state_e             state_q, state_d;
  desc_t                  cur_q, cur_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic                   flit_valid_q, flit_valid_d;
  flit_type_e             flit_type_q, flit_type_d;
  logic [FLIT_DATA_W-1:0] flit_data_q, flit_data_d;
  logic                   err_drop_q, err_drop_d;
  logic                   out_free, pld_ready_c, take_next, desc_ok;

  assign fifo_wdata     = '{dst_x: inj.desc_dst_x, dst_y: inj.desc_dst_y, len: inj.desc_len};
  assign inj.desc_ready = noc_rst_n && !fifo_full;
  assign fifo_push      = inj.desc_valid && inj.desc_ready;

  noc_inj_desc_fifo #(
    .Width (DescW),
    .Depth (DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (noc_clk),
    .rst_n (noc_rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign out_free = !flit_valid_q || inj.flit_ready;
  assign desc_ok  = ({1'b0, fifo_rdata.dst_x} < (COORD_W + 1)'(NocXSize)) &&
                    ({1'b0, fifo_rdata.dst_y} < (COORD_W + 1)'(NocYSize));

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    flit_valid_d = flit_valid_q && !inj.flit_ready;
    flit_type_d  = flit_type_q;
    flit_data_d  = flit_data_q;
    err_drop_d   = 1'b0;
    fifo_pop     = 1'b0;
    pld_ready_c  = 1'b0;
    take_next    = 1'b0;

    unique case (state_q)
      StIdle: begin
        take_next = out_free;
      end
      StSendHead: begin
        if (out_free) begin
          flit_valid_d = 1'b1;
          flit_data_d  = head_word(cur_q.dst_x, cur_q.dst_y, COORD_W'(X_ID), COORD_W'(Y_ID),
                                   cur_q.len, seq_q);
          seq_d        = seq_q + 1'b1;
          if (cur_q.len == '0) begin
            flit_type_d = FlitHeadTail;
            state_d     = StIdle;
            take_next   = 1'b1;
          end else begin
            flit_type_d = FlitHead;
            rem_d       = cur_q.len;
            state_d     = StSendPld;
          end
        end
      end
      StSendPld: begin
        pld_ready_c = out_free;
        if (inj.pld_valid && pld_ready_c) begin
          flit_valid_d = 1'b1;
          flit_data_d  = inj.pld_data;
          rem_d        = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            flit_type_d = FlitTail;
            state_d     = StIdle;
            take_next   = 1'b1;
          end else begin
            flit_type_d = FlitBody;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Popping while the last flit is loaded lets the next head follow without a bubble.
    if (take_next && !fifo_empty) begin
      fifo_pop = 1'b1;
      cur_d    = fifo_rdata;
      if (desc_ok) begin
        state_d = StSendHead;
      end else begin
        err_drop_d = 1'b1;
        state_d    = StIdle;
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      rem_q        <= '0;
      seq_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_type_q  <= FlitHead;
      flit_data_q  <= '0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rem_q        <= rem_d;
      seq_q        <= seq_d;
      flit_valid_q <= flit_valid_d;
      flit_type_q  <= flit_type_d;
      flit_data_q  <= flit_data_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign inj.pld_ready  = noc_rst_n && pld_ready_c;
  assign inj.flit_valid = flit_valid_q;
  assign inj.flit_type  = flit_type_q;
  assign inj.flit_data  = flit_data_q;
  assign inj.err_drop   = err_drop_q;

`ifdef NOC_INJ_STATS_EN
  logic [15:0] pkt_cnt_q, stall_cnt_q;
  logic        pkt_done, stall;

  assign pkt_done = flit_valid_q && inj.flit_ready &&
                    ((flit_type_q == FlitTail) || (flit_type_q == FlitHeadTail));
  assign stall    = flit_valid_q && !inj.flit_ready;

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pkt_done && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (stall && (stall_cnt_q != 16'hFFFF))  stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stat_pkt_cnt   = pkt_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
